// File: rtl/spell_mem_pkg.sv
// rtl/spell_mem_pkg.sv - shared types and constants for the spell memory arbiter
package spell_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

endpackage

// File: rtl/spell_rr_arb2.sv
// rtl/spell_rr_arb2.sv - two-way round-robin pick between core and host requests
module spell_rr_arb2
  import spell_mem_pkg::*;
(
  input  logic c_req,
  input  logic h_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = c_req | h_req;
    grant_id    = OWNER_CORE;
    if (c_req && h_req) begin
      // On a tie the side that did not win last time goes next.
      grant_id = (last_owner == OWNER_CORE) ? OWNER_HOST : OWNER_CORE;
    end else if (h_req) begin
      grant_id = OWNER_HOST;
    end
  end

endmodule

// File: rtl/spell_mem_arbiter.sv
// rtl/spell_mem_arbiter.sv - shares the single-port spell memory between core and host
module spell_mem_arbiter
  import spell_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c_req,
  input  logic [7:0] c_addr,
  input  logic       c_type_data,
  input  logic       c_write,
  input  logic [7:0] c_wdata,
  output logic       c_ack,
  output logic [7:0] c_rdata,
  input  logic       h_req,
  input  logic [7:0] h_addr,
  input  logic       h_type_data,
  input  logic       h_write,
  input  logic [7:0] h_wdata,
  output logic       h_ack,
  output logic [7:0] h_rdata,
  output logic       m_select,
  output logic [7:0] m_addr,
  output logic       m_type_data,
  output logic       m_write,
  output logic [7:0] m_data_in,
  input  logic [7:0] m_data_out,
  input  logic       m_data_ready,
  output logic       busy,
  output logic       owner
);

  state_t state;
  logic   grant_valid;
  logic   grant_id;

  spell_rr_arb2 u_arb (
    .c_req       (c_req),
    .h_req       (h_req),
    .last_owner  (owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // The m_* registers double as the latched transaction fields, so requester
  // changes after grant never reach the memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      m_select    <= 1'b0;
      m_addr      <= 8'h00;
      m_type_data <= 1'b0;
      m_write     <= 1'b0;
      m_data_in   <= 8'h00;
      c_ack       <= 1'b0;
      h_ack       <= 1'b0;
      c_rdata     <= 8'h00;
      h_rdata     <= 8'h00;
      busy        <= 1'b0;
      owner       <= OWNER_HOST;
    end else begin
      c_ack <= 1'b0;
      h_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner    <= grant_id;
            m_select <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_ACCESS;
            if (grant_id == OWNER_HOST) begin
              m_addr      <= h_addr;
              m_type_data <= h_type_data;
              m_write     <= h_write;
              m_data_in   <= h_wdata;
            end else begin
              m_addr      <= c_addr;
              m_type_data <= c_type_data;
              m_write     <= c_write;
              m_data_in   <= c_wdata;
            end
          end
        end
        ST_ACCESS: begin
          // m_select was low in IDLE, so ready here always belongs to this access.
          if (m_data_ready) begin
            m_select <= 1'b0;
            state    <= ST_RESP;
            if (owner == OWNER_HOST) begin
              h_ack <= 1'b1;
              if (!m_write) h_rdata <= m_data_out;
            end else begin
              c_ack <= 1'b1;
              if (!m_write) c_rdata <= m_data_out;
            end
          end
        end
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          m_select <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// tb/tb_spell_mem_arbiter.sv - directed self-checking bench for spell_mem_arbiter
module tb_spell_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c_req, c_type_data, c_write, c_ack;
  logic [7:0] c_addr, c_wdata, c_rdata;
  logic       h_req, h_type_data, h_write, h_ack;
  logic [7:0] h_addr, h_wdata, h_rdata;
  logic       m_select, m_type_data, m_write, m_data_ready;
  logic [7:0] m_addr, m_data_in, m_data_out;
  logic       busy, owner;

  int pass_cnt = 0;
  int total_cnt = 0;
  int h_ack_seen = 0;

  always #5 clk = ~clk;

  spell_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_addr(c_addr), .c_type_data(c_type_data), .c_write(c_write),
    .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .h_req(h_req), .h_addr(h_addr), .h_type_data(h_type_data), .h_write(h_write),
    .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .m_select(m_select), .m_addr(m_addr), .m_type_data(m_type_data), .m_write(m_write),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .m_data_ready(m_data_ready),
    .busy(busy), .owner(owner)
  );

  // Memory model: 512-cycle fill writes 0xFF everywhere, ready is a registered select.
  logic [7:0] mem [0:1][0:255];
  logic [9:0] fill_cnt = 10'd0;
  wire        fill_done = (fill_cnt == 10'd512);

  always @(posedge clk) begin
    if (!rst_n) m_data_ready <= 1'b0;
    else        m_data_ready <= m_select && fill_done;
    if (rst_n && !fill_done) begin
      mem[fill_cnt[8]][fill_cnt[7:0]] <= 8'hFF;
      fill_cnt <= fill_cnt + 10'd1;
    end
    if (m_select && fill_done) begin
      if (m_write) mem[m_type_data][m_addr] <= m_data_in;
      else         m_data_out <= mem[m_type_data][m_addr];
    end
  end

  always @(negedge clk) if (h_ack) h_ack_seen++;

  task automatic txn(input bit host, input logic [7:0] addr, input bit typ, input bit wr,
                     input logic [7:0] wd, input int limit, output int lat);
    @(negedge clk);
    if (host) begin
      h_req = 1'b1; h_addr = addr; h_type_data = typ; h_write = wr; h_wdata = wd;
    end else begin
      c_req = 1'b1; c_addr = addr; c_type_data = typ; c_write = wr; c_wdata = wd;
    end
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (host ? h_ack : c_ack) begin
        lat = i;
        break;
      end
    end
    c_req = 1'b0;
    h_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    c_req = 0; c_addr = 0; c_type_data = 0; c_write = 0; c_wdata = 0;
    h_req = 0; h_addr = 0; h_type_data = 0; h_write = 0; h_wdata = 0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({m_select, m_write, c_ack, h_ack, busy, owner} !== 6'b000001)
      $display("FAIL reset_ctrl got %b want 000001", {m_select, m_write, c_ack, h_ack, busy, owner});
    else pass_cnt++;
    total_cnt++;
    if ({m_addr, m_data_in, m_type_data, c_rdata, h_rdata} !== 33'd0)
      $display("FAIL reset_data got %h want 0", {m_addr, m_data_in, m_type_data, c_rdata, h_rdata});
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    int lat;
    int h0;
    h0 = h_ack_seen;
    txn(1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 1000, lat);
    total_cnt++;
    if (lat < 512 || lat > 530) $display("FAIL fill_latency got %0d want 512..530", lat);
    else pass_cnt++;
    total_cnt++;
    if (c_rdata !== 8'hFF) $display("FAIL fill_rdata got %h want ff", c_rdata);
    else pass_cnt++;
    total_cnt++;
    if (h_ack_seen !== h0) $display("FAIL fill_no_hack got %0d want %0d", h_ack_seen, h0);
    else pass_cnt++;
  endtask

  task automatic test_write_read;
    int lat;
    txn(1'b1, 8'h20, 1'b1, 1'b1, 8'h5A, 20, lat);
    total_cnt++;
    if (lat !== 3) $display("FAIL wr_latency got %0d want 3", lat);
    else pass_cnt++;
    txn(1'b0, 8'h20, 1'b1, 1'b0, 8'h00, 20, lat);
    total_cnt++;
    if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat);
    else pass_cnt++;
    total_cnt++;
    if (c_rdata !== 8'h5A) $display("FAIL rd_data got %h want 5a", c_rdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    int last_cyc;
    int cyc;
    logic [1:0] acks;
    txn(1'b1, 8'h40, 1'b1, 1'b1, 8'h77, 20, lat);
    @(negedge clk);
    c_req = 1; c_addr = 8'h20; c_type_data = 1; c_write = 0;
    h_req = 1; h_addr = 8'h40; h_type_data = 1; h_write = 0;
    cyc = 0;
    last_cyc = -1;
    for (int n = 0; n < 4; n++) begin
      acks = 2'b00;
      for (int w = 0; w < 20 && acks == 2'b00; w++) begin
        @(negedge clk);
        cyc++;
        acks = {h_ack, c_ack};
      end
      total_cnt++;
      if (acks !== ((n % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL b2b_grant%0d got %b want %b", n, acks, (n % 2 == 0) ? 2'b01 : 2'b10);
      else pass_cnt++;
      total_cnt++;
      if (owner !== ((n % 2 == 0) ? 1'b0 : 1'b1))
        $display("FAIL b2b_owner%0d got %b want %b", n, owner, n % 2);
      else pass_cnt++;
      total_cnt++;
      if ((n % 2 == 0) ? (c_rdata !== 8'h5A) : (h_rdata !== 8'h77))
        $display("FAIL b2b_rdata%0d got c=%h h=%h want c=5a h=77", n, c_rdata, h_rdata);
      else pass_cnt++;
      if (n > 0) begin
        total_cnt++;
        if (cyc - last_cyc !== 4) $display("FAIL b2b_spacing%0d got %0d want 4", n, cyc - last_cyc);
        else pass_cnt++;
      end
      last_cyc = cyc;
    end
    c_req = 0;
    h_req = 0;
  endtask

  task automatic test_latch;
    int lat;
    txn(1'b1, 8'h30, 1'b1, 1'b1, 8'h33, 20, lat);
    txn(1'b1, 8'h31, 1'b1, 1'b1, 8'h44, 20, lat);
    @(negedge clk);
    c_req = 1; c_addr = 8'h30; c_type_data = 1; c_write = 0;
    @(negedge clk);
    total_cnt++;
    if ({m_select, m_data_ready, busy} !== 3'b101)
      $display("FAIL latch_access1 got %b want 101", {m_select, m_data_ready, busy});
    else pass_cnt++;
    c_addr = 8'h31;
    @(negedge clk);
    total_cnt++;
    if (m_addr !== 8'h30) $display("FAIL latch_maddr got %h want 30", m_addr);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (c_ack !== 1'b1 || c_rdata !== 8'h33)
      $display("FAIL latch_result got ack=%b data=%h want ack=1 data=33", c_ack, c_rdata);
    else pass_cnt++;
    c_req = 0;
    @(negedge clk);
    total_cnt++;
    if (c_ack !== 1'b0 || busy !== 1'b0)
      $display("FAIL ack_one_cycle got ack=%b busy=%b want 0 0", c_ack, busy);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    logic any_ack;
    @(negedge clk);
    c_req = 1; c_addr = 8'h10; c_type_data = 0; c_write = 0;
    @(negedge clk);
    rst_n = 1'b0;
    c_req = 0;
    @(negedge clk);
    total_cnt++;
    if ({m_select, busy, c_ack, owner} !== 4'b0001)
      $display("FAIL midrst_state got %b want 0001", {m_select, busy, c_ack, owner});
    else pass_cnt++;
    rst_n = 1'b1;
    any_ack = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_ack = any_ack | c_ack | h_ack;
    end
    total_cnt++;
    if (any_ack !== 1'b0) $display("FAIL midrst_noack got %b want 0", any_ack);
    else pass_cnt++;
    c_req = 1; c_addr = 8'h20; c_type_data = 1;
    h_req = 1; h_addr = 8'h40; h_type_data = 1; h_write = 0;
    any_ack = 1'b0;
    for (int w = 0; w < 20 && !any_ack; w++) begin
      @(negedge clk);
      any_ack = c_ack | h_ack;
    end
    total_cnt++;
    if ({c_ack, h_ack} !== 2'b10) $display("FAIL midrst_tie got c=%b h=%b want c=1 h=0", c_ack, h_ack);
    else pass_cnt++;
    c_req = 0;
    h_req = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write_read;
    test_back_to_back;
    test_latch;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
